// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the oversampling UART receiver.
//                parity_e    - frame parity mode (none / even / odd)
//                rx_state_e  - receiver FSM state encoding
//                parity_calc - parity bit a transmitter would append
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int c_MAX_DATA_BITS = 9;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } rx_state_e;

    // Expected parity bit for a word; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    function automatic logic parity_calc(input logic [c_MAX_DATA_BITS-1:0] data,
                                         input parity_e                    mode);
        parity_calc = (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_sync
//  Description : 2-FF synchroniser for the asynchronous serial line plus a
//                3-sample history, shifted on every baud_tick, whose majority
//                is the noise-filtered bit value.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                rxd            - raw serial line (idle high)
//                baud_tick      - oversample strobe
//                rxd_s          - synchronised line
//                bit_maj        - majority of the last three tick samples
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    input  logic baud_tick,
    output logic rxd_s,
    output logic bit_maj
);

    logic [1:0] r_sync;
    logic [2:0] r_hist;

    // Both stages and the history preset to the idle level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= 2'b11;
            r_hist <= 3'b111;
        end else begin
            r_sync <= {r_sync[0], rxd};
            if (baud_tick) begin
                r_hist <= {r_hist[1:0], r_sync[1]};
            end
        end
    end

    assign rxd_s   = r_sync[1];
    assign bit_maj = (r_hist[0] & r_hist[1]) |
                     (r_hist[0] & r_hist[2]) |
                     (r_hist[1] & r_hist[2]);

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_core
//  Description : Parametrised oversampling UART receiver. LSB-first frames:
//                start, DATA_BITS data, optional parity, STOP_BITS stop.
//                Received words leave on a valid/ready interface together
//                with parity/frame error flags; overrun and break are pulses.
//  Ports       : clk, rst       - clock / synchronous active-high reset
//                rxd            - asynchronous serial line, idle high
//                baud_tick      - OVERSAMPLE strobes per bit time
//                m_data/m_valid/m_ready - output word handshake
//                m_parity_err, m_frame_err - qualify m_data
//                overrun_err    - pulse: frame dropped, output still full
//                break_det      - pulse: whole frame sampled low
//                busy           - FSM not in IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter int      OVERSAMPLE = 16,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 baud_tick,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 overrun_err,
    output logic                 break_det,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_LAST_STOP = 1'(STOP_BITS - 1);

    logic w_rxd_s;
    logic w_bit;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .baud_tick (baud_tick),
        .rxd_s     (w_rxd_s),
        .bit_maj   (w_bit)
    );

    rx_state_e            r_state,       w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt,         w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_idx,         w_idx_nxt;
    logic [DATA_BITS-1:0] r_data,        w_data_nxt;
    logic                 r_par_bit,     w_par_bit_nxt;
    logic                 r_stop_idx,    w_stop_idx_nxt;
    logic                 r_stop_err,    w_stop_err_nxt;
    logic                 r_first_stop0, w_first_stop0_nxt;
    logic                 w_complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_data        <= '0;
            r_par_bit     <= 1'b0;
            r_stop_idx    <= 1'b0;
            r_stop_err    <= 1'b0;
            r_first_stop0 <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_data        <= w_data_nxt;
            r_par_bit     <= w_par_bit_nxt;
            r_stop_idx    <= w_stop_idx_nxt;
            r_stop_err    <= w_stop_err_nxt;
            r_first_stop0 <= w_first_stop0_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_idx_nxt         = r_idx;
        w_data_nxt        = r_data;
        w_par_bit_nxt     = r_par_bit;
        w_stop_idx_nxt    = r_stop_idx;
        w_stop_err_nxt    = r_stop_err;
        w_first_stop0_nxt = r_first_stop0;
        w_complete        = 1'b0;
        if (baud_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rxd_s) begin
                        w_state_nxt = ST_START;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_CNT_HALF) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        if (w_bit) begin
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt       = ST_DATA;
                            w_cnt_nxt         = '0;
                            w_idx_nxt         = '0;
                            w_par_bit_nxt     = 1'b0;
                            w_stop_err_nxt    = 1'b0;
                            w_first_stop0_nxt = 1'b0;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_cnt_nxt         = '0;
                        w_data_nxt[r_idx] = w_bit;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            w_stop_idx_nxt = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + c_IDX_W'(1);
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_cnt_nxt     = '0;
                        w_par_bit_nxt = w_bit;
                        w_state_nxt   = ST_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_CNT_FULL) begin
                        w_cnt_nxt = '0;
                        if (!w_bit) begin
                            w_stop_err_nxt = 1'b1;
                        end
                        if (r_stop_idx == 1'b0) begin
                            w_first_stop0_nxt = ~w_bit;
                        end
                        if (r_stop_idx == c_LAST_STOP) begin
                            w_complete  = 1'b1;
                            // A low stop may be a break: wait for the line to
                            // return high so a held-low line never re-triggers.
                            w_state_nxt = (r_stop_err | ~w_bit) ? ST_WAIT_IDLE : ST_IDLE;
                        end else begin
                            w_stop_idx_nxt = 1'b1;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_rxd_s) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Frame result, valid only while w_complete is high (the final stop
    // sample is still in flight, so it is folded in from w_bit).
    logic [c_MAX_DATA_BITS-1:0] w_data_ext;
    logic                       w_frame_err;
    logic                       w_par_err;
    logic                       w_first_stop0;
    logic                       w_break;

    assign w_data_ext    = c_MAX_DATA_BITS'(r_data);
    assign w_frame_err   = r_stop_err | ~w_bit;
    assign w_par_err     = (PARITY != PAR_NONE) &&
                           (r_par_bit != parity_calc(w_data_ext, PARITY));
    assign w_first_stop0 = (r_stop_idx == 1'b0) ? ~w_bit : r_first_stop0;
    assign w_break       = (r_data == '0) &&
                           ((PARITY == PAR_NONE) || !r_par_bit) &&
                           w_first_stop0;

    logic [DATA_BITS-1:0] r_m_data;
    logic                 r_m_valid;
    logic                 r_m_parity_err;
    logic                 r_m_frame_err;
    logic                 r_overrun;
    logic                 r_break;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_data       <= '0;
            r_m_valid      <= 1'b0;
            r_m_parity_err <= 1'b0;
            r_m_frame_err  <= 1'b0;
            r_overrun      <= 1'b0;
            r_break        <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            r_break   <= w_complete & w_break;
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_complete) begin
                // A word being accepted this cycle frees the slot for the new one.
                if (!r_m_valid || m_ready) begin
                    r_m_data       <= r_data;
                    r_m_parity_err <= w_par_err;
                    r_m_frame_err  <= w_frame_err;
                    r_m_valid      <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign m_parity_err = r_m_parity_err;
    assign m_frame_err  = r_m_frame_err;
    assign overrun_err  = r_overrun;
    assign break_det    = r_break;
    assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_core
//  Description : Self-checking bench for uart_rx_core. Two instances: 8N1
//                and 8E2, each on its own serial line. Frames are built bit
//                by bit at 16 ticks per bit; received words are collected by
//                a monitor and compared with values worked out from the frame
//                contents (table, hand-written sequences and random frames).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int OVS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       baud_tick = 1'b0;
    logic [1:0] div = 2'd0;

    always @(posedge clk) begin
        div       <= div + 2'd1;
        baud_tick <= (div == 2'd3);
    end

    logic       rxd_n, m_ready_n, m_valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n;
    logic [7:0] m_data_n;
    logic       rxd_e, m_ready_e, m_valid_e, perr_e, ferr_e, ovr_e, brk_e, busy_e;
    logic [7:0] m_data_e;

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(PAR_NONE), .STOP_BITS(1)) u_dut_n (
        .clk(clk), .rst(rst), .rxd(rxd_n), .baud_tick(baud_tick),
        .m_data(m_data_n), .m_valid(m_valid_n), .m_ready(m_ready_n),
        .m_parity_err(perr_n), .m_frame_err(ferr_n), .overrun_err(ovr_n),
        .break_det(brk_n), .busy(busy_n)
    );

    uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(OVS), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_dut_e (
        .clk(clk), .rst(rst), .rxd(rxd_e), .baud_tick(baud_tick),
        .m_data(m_data_e), .m_valid(m_valid_e), .m_ready(m_ready_e),
        .m_parity_err(perr_e), .m_frame_err(ferr_e), .overrun_err(ovr_e),
        .break_det(brk_e), .busy(busy_e)
    );

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } word_t;

    word_t q_n[$];
    word_t q_e[$];
    int    ovr_cnt_n = 0, brk_cnt_n = 0, vcyc_n = 0;
    int    ovr_cnt_e = 0, brk_cnt_e = 0;

    always @(negedge clk) begin
        if (!rst && m_valid_n && m_ready_n) q_n.push_back({ferr_n, perr_n, m_data_n});
        if (!rst && m_valid_e && m_ready_e) q_e.push_back({ferr_e, perr_e, m_data_e});
        if (ovr_n) ovr_cnt_n++;
        if (brk_n) brk_cnt_n++;
        if (m_valid_n) vcyc_n++;
        if (ovr_e) ovr_cnt_e++;
        if (brk_e) brk_cnt_e++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_tick();
        do @(negedge clk); while (!baud_tick);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic set_line(input bit sel, input logic b);
        if (sel) rxd_e = b;
        else     rxd_n = b;
    endtask

    task automatic send_bit(input bit sel, input logic b);
        set_line(sel, b);
        wait_ticks(OVS);
    endtask

    // sel=0: 8N1 line (p ignored, stops[0] only); sel=1: 8E2 line.
    task automatic send_frame(input bit sel, input logic [7:0] d, input logic p,
                              input logic [1:0] stops);
        wait_tick();
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (sel) send_bit(sel, p);
        send_bit(sel, stops[0]);
        if (sel) send_bit(sel, stops[1]);
        set_line(sel, 1'b1);
        wait_ticks(2 * OVS);
    endtask

    // Reference: what the receiver should report for a frame.
    function automatic word_t model_word(input bit sel, input logic [7:0] d,
                                         input logic p, input logic [1:0] stops);
        word_t w;
        w.data = d;
        w.perr = sel ? (((^d) ^ p) != 1'b0) : 1'b0;
        w.ferr = sel ? !(stops[0] && stops[1]) : !stops[0];
        return w;
    endfunction

    function automatic int model_brk(input bit sel, input logic [7:0] d,
                                     input logic p, input logic [1:0] stops);
        return (d == 8'h00 && (!sel || p == 1'b0) && stops[0] == 1'b0) ? 1 : 0;
    endfunction

    task automatic check_frame(input string name, input bit sel, input word_t exp_w,
                               input int exp_brk, input int brk0);
        word_t got;
        if (sel) begin
            chk({name, "_count"}, 32'(q_e.size()), 32'd1);
            chk({name, "_brk"}, 32'(brk_cnt_e - brk0), 32'(exp_brk));
            got = (q_e.size() > 0) ? q_e.pop_front() : '0;
        end else begin
            chk({name, "_count"}, 32'(q_n.size()), 32'd1);
            chk({name, "_brk"}, 32'(brk_cnt_n - brk0), 32'(exp_brk));
            got = (q_n.size() > 0) ? q_n.pop_front() : '0;
        end
        chk({name, "_word"}, 32'(got), 32'(exp_w));
        if (sel) q_e.delete();
        else     q_n.delete();
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic       p;
        logic [1:0] stops;
        logic [7:0] ed;
        logic       eperr;
        logic       eferr;
        int         ebrk;
    } vec_t;

    vec_t tbl[11];

    initial begin : watchdog
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        word_t w;
        int    b0, v0, o0;
        logic [7:0] d;
        logic       p;
        logic [1:0] s;

        //            sel  data   p    stops  exp_d  perr ferr brk
        tbl[0]  = '{1'b1, 8'hA5, 1'b1, 2'b11, 8'hA5, 1'b1, 1'b0, 0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0, 0};
        tbl[2]  = '{1'b1, 8'h00, 1'b0, 2'b11, 8'h00, 1'b0, 1'b0, 0};
        tbl[3]  = '{1'b1, 8'hFF, 1'b0, 2'b11, 8'hFF, 1'b0, 1'b0, 0};
        tbl[4]  = '{1'b1, 8'h01, 1'b0, 2'b11, 8'h01, 1'b1, 1'b0, 0};
        tbl[5]  = '{1'b1, 8'h80, 1'b1, 2'b10, 8'h80, 1'b0, 1'b1, 0};
        tbl[6]  = '{1'b1, 8'h3C, 1'b0, 2'b01, 8'h3C, 1'b0, 1'b1, 0};
        tbl[7]  = '{1'b1, 8'h00, 1'b0, 2'b10, 8'h00, 1'b0, 1'b1, 1};
        tbl[8]  = '{1'b0, 8'h55, 1'b0, 2'b01, 8'h55, 1'b0, 1'b0, 0};
        tbl[9]  = '{1'b0, 8'hAA, 1'b0, 2'b00, 8'hAA, 1'b0, 1'b1, 0};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 2'b00, 8'h00, 1'b0, 1'b1, 1};

        rst = 1'b1; rxd_n = 1'b1; rxd_e = 1'b1; m_ready_n = 1'b1; m_ready_e = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_n", {m_data_n, m_valid_n, perr_n, ferr_n, ovr_n, brk_n, busy_n}, 32'd0);
        chk("reset_outputs_e", {m_data_e, m_valid_e, perr_e, ferr_e, ovr_e, brk_e, busy_e}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        wait_ticks(4);

        // 8N1 0x55 with m_ready held: one valid cycle, clean flags.
        v0 = vcyc_n; b0 = brk_cnt_n;
        send_frame(1'b0, 8'h55, 1'b0, 2'b11);
        chk("f55_valid_cycles", 32'(vcyc_n - v0), 32'd1);
        check_frame("f55", 1'b0, model_word(1'b0, 8'h55, 1'b0, 2'b11), 0, b0);

        // Table of hand-worked frames.
        for (int i = 0; i < 11; i++) begin
            b0 = tbl[i].sel ? brk_cnt_e : brk_cnt_n;
            send_frame(tbl[i].sel, tbl[i].d, tbl[i].p, tbl[i].stops);
            w = '{ferr: tbl[i].eferr, perr: tbl[i].eperr, data: tbl[i].ed};
            check_frame($sformatf("tbl%0d", i), tbl[i].sel, w, tbl[i].ebrk, b0);
        end

        // False start: 4 ticks low, then back high.
        v0 = vcyc_n;
        wait_tick();
        set_line(1'b0, 1'b0);
        wait_ticks(4);
        chk("glitch_busy_start", 32'(busy_n), 32'd1);
        set_line(1'b0, 1'b1);
        wait_ticks(3);
        chk("glitch_busy_mid", 32'(busy_n), 32'd1);
        wait_ticks(3);
        chk("glitch_busy_end", 32'(busy_n), 32'd0);
        wait_ticks(2 * OVS);
        chk("glitch_no_valid", 32'(vcyc_n - v0), 32'd0);
        chk("glitch_no_word", 32'(q_n.size()), 32'd0);

        // Break: line low for 40 bit times.
        b0 = brk_cnt_n;
        wait_tick();
        set_line(1'b0, 1'b0);
        wait_ticks(40 * OVS);
        chk("break_busy_held", 32'(busy_n), 32'd1);
        check_frame("break", 1'b0, '{ferr: 1'b1, perr: 1'b0, data: 8'h00}, 1, b0);
        set_line(1'b0, 1'b1);
        wait_ticks(4);
        chk("break_busy_release", 32'(busy_n), 32'd0);
        wait_ticks(2 * OVS);
        chk("break_no_more", 32'(q_n.size()), 32'd0);

        // Overrun: consumer stalled across two frames.
        @(posedge clk); #1 m_ready_n = 1'b0;
        o0 = ovr_cnt_n;
        send_frame(1'b0, 8'h12, 1'b0, 2'b11);
        send_frame(1'b0, 8'h34, 1'b0, 2'b11);
        chk("ovr_pulses", 32'(ovr_cnt_n - o0), 32'd1);
        chk("ovr_valid_held", 32'(m_valid_n), 32'd1);
        chk("ovr_data_kept", 32'(m_data_n), 32'h12);
        @(posedge clk); #1 m_ready_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ovr_valid_clear", 32'(m_valid_n), 32'd0);
        check_frame("ovr_accept", 1'b0, '{ferr: 1'b0, perr: 1'b0, data: 8'h12}, 0, brk_cnt_n);

        // Reset mid-frame with a word pending.
        @(posedge clk); #1 m_ready_n = 1'b0;
        send_frame(1'b0, 8'h5A, 1'b0, 2'b11);
        chk("rst_pending_valid", 32'(m_valid_n), 32'd1);
        d = 8'hC3;
        wait_tick();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, d[i]);
        set_line(1'b0, d[3]);
        wait_ticks(OVS / 2);
        @(posedge clk); #1 rst = 1'b1; rxd_n = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy_n), 32'd0);
        chk("rst_valid", 32'(m_valid_n), 32'd0);
        @(posedge clk); #1 m_ready_n = 1'b1;
        wait_ticks(2 * OVS);
        chk("rst_no_word", 32'(q_n.size()), 32'd0);
        send_frame(1'b0, 8'h3C, 1'b0, 2'b11);
        check_frame("rst_next", 1'b0, '{ferr: 1'b0, perr: 1'b0, data: 8'h3C}, 0, brk_cnt_n);

        // Random frames on both configurations against the reference model.
        o0 = ovr_cnt_n + ovr_cnt_e;
        for (int k = 0; k < 24; k++) begin
            bit sel;
            sel = (k % 2) == 1;
            d = 8'($urandom);
            if ($urandom_range(0, 5) == 0) d = 8'h00;
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s[0] = ($urandom_range(0, 4) != 0);
            s[1] = ($urandom_range(0, 4) != 0);
            b0 = sel ? brk_cnt_e : brk_cnt_n;
            send_frame(sel, d, p, s);
            check_frame($sformatf("rand%0d", k), sel, model_word(sel, d, p, s),
                        model_brk(sel, d, p, s), b0);
        end
        chk("rand_no_overrun", 32'(ovr_cnt_n + ovr_cnt_e - o0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
